// File: rtl/uart_cmd_scheduler.sv
// UART command scheduler: pops RX bytes, drives counter controls,
// queues ASCII acknowledge/status replies into the TX FIFO.
//
// Ports:
//   clk, rst        clock, async active-low reset
//   rx_empty/rdata  RX FIFO status and FWFT head byte
//   rx_pop          one-cycle RX pop strobe
//   tx_full         TX FIFO full flag
//   tx_push/wdata   TX push strobe and byte
//   enable_cmd      counter run level
//   clear_cmd       one-cycle counter clear pulse
//   mode_cmd        count direction (1 = down)
//   busy            FSM not in IDLE
module uart_cmd_scheduler #(
  parameter bit ECHO_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_empty,
  input  logic [7:0] rx_rdata,
  output logic       rx_pop,
  input  logic       tx_full,
  output logic       tx_push,
  output logic [7:0] tx_wdata,
  output logic       enable_cmd,
  output logic       clear_cmd,
  output logic       mode_cmd,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    RESP
  } state_t;

  localparam logic [2:0] ECHO_LEN =
    ECHO_EN ? 3'd3 : 3'd0;

  state_t     r_state;
  logic [7:0] r_byte;
  logic [7:0] r_reply [4];
  logic [2:0] r_len;
  logic [1:0] r_idx;
  logic       r_apply;
  logic       r_tgl_en;
  logic       r_tgl_md;
  logic       r_clr;

  logic       w_is_r;
  logic       w_is_c;
  logic       w_is_m;
  logic       w_is_s;
  logic       w_is_eol;
  logic [2:0] w_len;
  logic [7:0] w_rep [4];
  logic       w_tgl_en;
  logic       w_tgl_md;
  logic       w_clr;
  logic       w_last;

  assign w_is_r   = (r_byte == 8'h72) ||
                    (r_byte == 8'h52);
  assign w_is_c   = (r_byte == 8'h63) ||
                    (r_byte == 8'h43);
  assign w_is_m   = (r_byte == 8'h6D) ||
                    (r_byte == 8'h4D);
  assign w_is_s   = (r_byte == 8'h73) ||
                    (r_byte == 8'h53);
  assign w_is_eol = (r_byte == 8'h0D) ||
                    (r_byte == 8'h0A);

  assign w_last = ({1'b0, r_idx} ==
                   (r_len - 3'd1));

  always_comb begin
    w_len    = 3'd0;
    w_rep[0] = r_byte;
    w_rep[1] = 8'h0D;
    w_rep[2] = 8'h0A;
    w_rep[3] = 8'h00;
    w_tgl_en = 1'b0;
    w_tgl_md = 1'b0;
    w_clr    = 1'b0;
    unique case (1'b1)
      w_is_r: begin
        w_tgl_en = 1'b1;
        w_len    = ECHO_LEN;
      end
      w_is_c: begin
        w_clr = 1'b1;
        w_len = ECHO_LEN;
      end
      w_is_m: begin
        w_tgl_md = 1'b1;
        w_len    = ECHO_LEN;
      end
      w_is_s: begin
        // status reflects controls as seen now
        w_rep[0] = enable_cmd ? 8'h52 : 8'h53;
        w_rep[1] = mode_cmd ? 8'h44 : 8'h55;
        w_rep[2] = 8'h0D;
        w_rep[3] = 8'h0A;
        w_len    = 3'd4;
      end
      w_is_eol: begin
        w_len = 3'd0;
      end
      default: begin
        w_rep[0] = 8'h3F;
        w_len    = ECHO_LEN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      rx_pop     <= 1'b0;
      tx_push    <= 1'b0;
      tx_wdata   <= 8'h00;
      enable_cmd <= 1'b0;
      clear_cmd  <= 1'b0;
      mode_cmd   <= 1'b0;
      busy       <= 1'b0;
      r_byte     <= 8'h00;
      r_len      <= 3'd0;
      r_idx      <= 2'd0;
      r_apply    <= 1'b0;
      r_tgl_en   <= 1'b0;
      r_tgl_md   <= 1'b0;
      r_clr      <= 1'b0;
      for (int i = 0; i < 4; i++)
        r_reply[i] <= 8'h00;
    end else begin
      rx_pop    <= 1'b0;
      tx_push   <= 1'b0;
      clear_cmd <= 1'b0;
      // decoded control effects land one
      // cycle after DECODE
      if (r_apply) begin
        enable_cmd <= enable_cmd ^ r_tgl_en;
        mode_cmd   <= mode_cmd ^ r_tgl_md;
        clear_cmd  <= r_clr;
        r_apply    <= 1'b0;
      end
      unique case (r_state)
        IDLE: begin
          // r_apply holds off the next pop so
          // silent bytes pace at one per 3 cycles
          if (!rx_empty && !r_apply) begin
            r_byte  <= rx_rdata;
            rx_pop  <= 1'b1;
            r_state <= DECODE;
            busy    <= 1'b1;
          end
        end
        DECODE: begin
          r_apply  <= 1'b1;
          r_tgl_en <= w_tgl_en;
          r_tgl_md <= w_tgl_md;
          r_clr    <= w_clr;
          r_reply  <= w_rep;
          r_len    <= w_len;
          r_idx    <= 2'd0;
          if (w_len != 3'd0) begin
            r_state <= RESP;
            busy    <= 1'b1;
          end else begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        end
        RESP: begin
          if (!tx_full) begin
            tx_push  <= 1'b1;
            tx_wdata <= r_reply[r_idx];
            r_idx    <= r_idx + 2'd1;
            if (w_last) begin
              r_state <= IDLE;
              busy    <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_scheduler.sv
// Testbench for uart_cmd_scheduler: table of command bytes
// with expected replies/controls, plus stall, no-echo, reset cases.
module tb_uart_cmd_scheduler;

  logic       clk;
  logic       rst;
  logic       rx_empty;
  logic [7:0] rx_rdata;
  logic       rx_pop;
  logic       tx_full;
  logic       tx_push;
  logic [7:0] tx_wdata;
  logic       enable_cmd;
  logic       clear_cmd;
  logic       mode_cmd;
  logic       busy;

  logic       rx_empty0;
  logic [7:0] rx_rdata0;
  logic       rx_pop0;
  logic       tx_full0;
  logic       tx_push0;
  logic [7:0] tx_wdata0;
  logic       enable0;
  logic       clear0;
  logic       mode0;
  logic       busy0;

  uart_cmd_scheduler #(.ECHO_EN(1'b1)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .rx_empty   (rx_empty),
    .rx_rdata   (rx_rdata),
    .rx_pop     (rx_pop),
    .tx_full    (tx_full),
    .tx_push    (tx_push),
    .tx_wdata   (tx_wdata),
    .enable_cmd (enable_cmd),
    .clear_cmd  (clear_cmd),
    .mode_cmd   (mode_cmd),
    .busy       (busy)
  );

  uart_cmd_scheduler #(.ECHO_EN(1'b0)) u_dut0 (
    .clk        (clk),
    .rst        (rst),
    .rx_empty   (rx_empty0),
    .rx_rdata   (rx_rdata0),
    .rx_pop     (rx_pop0),
    .tx_full    (tx_full0),
    .tx_push    (tx_push0),
    .tx_wdata   (tx_wdata0),
    .enable_cmd (enable0),
    .clear_cmd  (clear0),
    .mode_cmd   (mode0),
    .busy       (busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int viol = 0;
  int pop_cyc = -1;
  int pop_cnt = 0;
  int first_push = -1;
  int last_push = -1;
  int en_chg = -1;
  int md_chg = -1;
  int clr_cnt = 0;
  int clr_cyc = -1;
  int push0_cnt = 0;
  logic en_prev = 1'b0;
  logic md_prev = 1'b0;
  logic [7:0] txq [$];

  // each posedge observes the cycle that is ending (index cyc)
  always @(posedge clk) begin
    if (tx_push === 1'b1) begin
      txq.push_back(tx_wdata);
      if (first_push < 0) first_push = cyc;
      last_push = cyc;
      if (tx_full) viol++;
    end
    if (rx_pop === 1'b1) begin
      pop_cyc = cyc;
      pop_cnt++;
      if (rx_empty) viol++;
    end
    if (clear_cmd === 1'b1) begin
      clr_cnt++;
      clr_cyc = cyc;
    end
    if (enable_cmd !== en_prev) en_chg = cyc;
    if (mode_cmd !== md_prev) md_chg = cyc;
    en_prev = enable_cmd;
    md_prev = mode_cmd;
    if (tx_push0 === 1'b1) push0_cnt++;
    if (rx_pop0 === 1'b1 && rx_empty0) viol++;
    cyc++;
  end

  typedef struct {
    logic [7:0] b;
    int         n;
    logic [7:0] r0;
    logic [7:0] r1;
    logic [7:0] r2;
    logic [7:0] r3;
    int         en;
    int         md;
    int         clr;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  task automatic wait_pop(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rx_pop) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_vec(input int id,
                         input vec_t v);
    bit ok;
    int en_b;
    int md_b;
    logic [7:0] e [4];
    e = '{v.r0, v.r1, v.r2, v.r3};
    @(negedge clk);
    en_b = enable_cmd;
    md_b = mode_cmd;
    txq.delete();
    first_push = -1;
    last_push = -1;
    en_chg = -1;
    md_chg = -1;
    clr_cnt = 0;
    clr_cyc = -1;
    rx_rdata = v.b;
    rx_empty = 1'b0;
    wait_pop(ok);
    chk($sformatf("v%0d pop", id), ok, 1);
    @(negedge clk);
    rx_empty = 1'b1;
    repeat (6) @(negedge clk);
    chk($sformatf("v%0d txlen", id),
        txq.size(), v.n);
    for (int i = 0; i < v.n && i < txq.size(); i++)
      chk($sformatf("v%0d txbyte%0d", id, i),
          txq[i], e[i]);
    chk($sformatf("v%0d enable", id),
        enable_cmd, v.en);
    chk($sformatf("v%0d mode", id),
        mode_cmd, v.md);
    chk($sformatf("v%0d clears", id),
        clr_cnt, v.clr);
    chk($sformatf("v%0d busy", id), busy, 0);
    if (v.n > 0) begin
      chk($sformatf("v%0d push_lat", id),
          first_push - pop_cyc, 2);
      chk($sformatf("v%0d push_end", id),
          last_push - pop_cyc, v.n + 1);
    end
    if (v.en != en_b)
      chk($sformatf("v%0d en_lat", id),
          en_chg - pop_cyc, 2);
    if (v.md != md_b)
      chk($sformatf("v%0d md_lat", id),
          md_chg - pop_cyc, 2);
    if (v.clr != 0)
      chk($sformatf("v%0d clr_lat", id),
          clr_cyc - pop_cyc, 2);
  endtask

  initial begin
    bit ok;
    int p0;
    int idx;
    bit adv;
    int pc [3];
    logic [7:0] b0 [3];
    vec_t sv;

    // 'm' 'S' 'r' 's' 'C' 'R' 'x' CR 'M' 's' LF
    tbl[0]  = '{8'h6D, 3, 8'h6D, 8'h0D, 8'h0A, 8'h00, 0, 1, 0};
    tbl[1]  = '{8'h53, 4, 8'h53, 8'h44, 8'h0D, 8'h0A, 0, 1, 0};
    tbl[2]  = '{8'h72, 3, 8'h72, 8'h0D, 8'h0A, 8'h00, 1, 1, 0};
    tbl[3]  = '{8'h73, 4, 8'h52, 8'h44, 8'h0D, 8'h0A, 1, 1, 0};
    tbl[4]  = '{8'h43, 3, 8'h43, 8'h0D, 8'h0A, 8'h00, 1, 1, 1};
    tbl[5]  = '{8'h52, 3, 8'h52, 8'h0D, 8'h0A, 8'h00, 0, 1, 0};
    tbl[6]  = '{8'h78, 3, 8'h3F, 8'h0D, 8'h0A, 8'h00, 0, 1, 0};
    tbl[7]  = '{8'h0D, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0};
    tbl[8]  = '{8'h4D, 3, 8'h4D, 8'h0D, 8'h0A, 8'h00, 0, 0, 0};
    tbl[9]  = '{8'h73, 4, 8'h53, 8'h55, 8'h0D, 8'h0A, 0, 0, 0};
    tbl[10] = '{8'h0A, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0};

    rst = 1'b0;
    rx_empty = 1'b1;
    rx_rdata = 8'h00;
    tx_full = 1'b0;
    rx_empty0 = 1'b1;
    rx_rdata0 = 8'h00;
    tx_full0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst rx_pop", rx_pop, 0);
    chk("rst tx_push", tx_push, 0);
    chk("rst tx_wdata", tx_wdata, 0);
    chk("rst ctrl", {enable_cmd, clear_cmd, mode_cmd}, 0);
    chk("rst busy", busy, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 11; i++)
      run_vec(i, tbl[i]);

    // TX stall: 'r' with TX full, 'm' waiting behind it
    @(negedge clk);
    tx_full = 1'b1;
    txq.delete();
    last_push = -1;
    rx_rdata = 8'h72;
    rx_empty = 1'b0;
    wait_pop(ok);
    chk("stall pop", ok, 1);
    @(negedge clk);
    rx_rdata = 8'h6D;
    p0 = pop_cnt;
    repeat (10) @(negedge clk);
    chk("stall pushes", txq.size(), 0);
    chk("stall busy", busy, 1);
    chk("stall no_pop", pop_cnt, p0);
    tx_full = 1'b0;
    wait_pop(ok);
    chk("stall pop2", ok, 1);
    chk("stall pop_after_push", cyc > last_push, 1);
    chk("stall txlen", txq.size(), 3);
    if (txq.size() == 3) begin
      chk("stall b0", txq[0], 8'h72);
      chk("stall b1", txq[1], 8'h0D);
      chk("stall b2", txq[2], 8'h0A);
    end
    @(negedge clk);
    rx_empty = 1'b1;
    repeat (6) @(negedge clk);
    chk("stall txlen2", txq.size(), 6);
    if (txq.size() == 6)
      chk("stall m_echo", txq[3], 8'h6D);
    chk("stall enable", enable_cmd, 1);
    chk("stall mode", mode_cmd, 1);

    // no-echo instance: 'x', CR, 'r' queued back to back
    b0 = '{8'h78, 8'h0D, 8'h72};
    pc = '{0, 0, 0};
    idx = 0;
    adv = 1'b0;
    @(negedge clk);
    rx_rdata0 = b0[0];
    rx_empty0 = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (adv) begin
        idx++;
        if (idx < 3) rx_rdata0 = b0[idx];
        else rx_empty0 = 1'b1;
        adv = 1'b0;
      end
      if (rx_pop0 && idx < 3) begin
        pc[idx] = cyc;
        adv = 1'b1;
      end
    end
    chk("noecho pops", idx, 3);
    chk("noecho gap1", (pc[1] - pc[0]) >= 3, 1);
    chk("noecho gap2", (pc[2] - pc[1]) >= 3, 1);
    chk("noecho pushes", push0_cnt, 0);
    chk("noecho enable", enable0, 1);
    chk("noecho mode", mode0, 0);

    // reset in the second RESP cycle of a '?' reply
    @(negedge clk);
    rx_rdata = 8'h78;
    rx_empty = 1'b0;
    wait_pop(ok);
    chk("rstmid pop", ok, 1);
    @(negedge clk);
    rx_empty = 1'b1;
    @(negedge clk);
    chk("rstmid pushing", tx_push, 1);
    rst = 1'b0;
    #1;
    chk("rstmid tx", {tx_push, tx_wdata}, 0);
    chk("rstmid ctrl",
        {enable_cmd, clear_cmd, mode_cmd}, 0);
    chk("rstmid busy_pop", {busy, rx_pop}, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    sv = '{8'h73, 4, 8'h53, 8'h55, 8'h0D, 8'h0A, 0, 0, 0};
    run_vec(99, sv);

    chk("protocol", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
